led_ctrl: RTL
=============

# led_ctrl

Parametrised memory-mapped LED output controller that replaces the fixed 8-bit LED latch on the MemOrIO bus. It holds up to 32 LED data bits in two 16-bit halves and adds per-LED hardware blinking from a free-running prescaler, global PWM dimming and register readback. It sits between the MemOrIO chip-select decode (`ledcs`) and the board LED pins.

## Interface
- `LED_W`, default 16: LED count; must be one of 8, 16, 24 or 32.
- `PRESC_W`, default 22: prescaler width; one tick every 2^PRESC_W cycles.
- `led_clk`, input, 1: clock (cpu_clk).
- `ledrst`, input, 1: reset; asynchronous, active-high.
- `ledcs`, input, 1: chip select from MemOrIO decode.
- `ledwrite`, input, 1: write strobe; a write happens on a rising edge with `ledcs`=1 and `ledwrite`=1.
- `ledaddr`, input, 3: register select.
- `ledwdata`, input, 16: write data.
- `ledrdata`, output, 16: combinational readback of the register selected by `ledaddr`. It reads 0 when `ledcs`=0.
- `ledout`, output, LED_W: registered LED drive.

## Operation
- Register map:
  - 000 DATA_LO: data[15:0].
  - 001 DATA_HI: data[31:16].
  - 010 BLINK_LO: mask[15:0].
  - 011 BLINK_HI: mask[31:16].
  - 100 CTRL: [7:0] duty, [8] blink_en; other bits read 0.
  - 101 PERIOD: [15:0] blink half-period, in ticks minus 1.
  - 110 and 111: reserved; writes are ignored and reads return 0.
- Bits at or above LED_W are not stored, ignore writes and read 0.
- Reset values: data 0, mask 0, duty 8'hFF, blink_en 0, period 0, phase 1, all counters 0, `ledout` 0.
- Prescaler: a PRESC_W-bit counter that increments every cycle and wraps. `tick`=1 for the one cycle in which the counter is all ones.
- Blink counter: 16 bits. On `tick`:
  - If the counter equals `period`, it clears to 0 and `phase` toggles.
  - Otherwise it increments by 1.
  - With `period`=0, `phase` toggles on every tick.
- PWM: an 8-bit counter that increments every cycle and wraps. `pwm_on` = (duty==8'hFF) | (pwm_cnt < duty). Duty 0 holds all LEDs dark.
- Next output per bit i: `ledout[i]` <= data[i] & (~(blink_en & mask[i]) | phase) & pwm_on.
- With blink_en=0 the mask is ignored, but the blink counter and phase keep running.

## Timing
- A write lands in its register at edge N. `ledout` reflects it at edge N+1, i.e. 1-cycle latency.
- Writing PERIOD at edge N also clears the blink counter to 0 and sets phase to 1 at edge N. This write takes priority over a tick in the same cycle.
- Writing BLINK_* or CTRL does not disturb any counter or phase.
- A DATA write coincident with a tick or phase toggle: both take effect at the same edge. `ledout` at N+1 uses the new data and the new phase.
- Blink timing: phase toggles every (period+1)·2^PRESC_W cycles. The full blink period is twice that.
- Reset asserted mid-operation: all registers, counters and `ledout` return to reset values immediately (asynchronous). After deassertion, the first tick occurs 2^PRESC_W cycles after the first active edge.
- Readback is combinational from the stored registers, so a read returns the written value in the cycle after the write edge.

## Configuration
- Macro `LED_PWM_EN`.
- Defined: the PWM counter and the CTRL[7:0] duty field exist as described above.
- Undefined:
  - No PWM counter is built and `pwm_on` is tied to 1.
  - Writes to CTRL[7:0] are ignored and CTRL[7:0] reads 8'hFF.
  - blink_en in CTRL[8] is unaffected.

## Test plan
- Reset and basic write, LED_W=16: reset, then write DATA_LO=16'hA5C3 -> `ledout`=16'hA5C3 one cycle after the write edge; `ledrdata` at addr 000 reads 16'hA5C3.
- Width masking, LED_W=8: write DATA_LO=16'hFFFF and DATA_HI=16'h1234 -> `ledout`=8'hFF; addr 000 reads 16'h00FF; addr 001 reads 0.
- Blink, PRESC_W=4:
  - Setup: DATA_LO=16'h00FF, BLINK_LO=16'h000F, PERIOD=1, CTRL=16'h01FF.
  - Low nibble toggles every 32 cycles, starting on.
  - `ledout` alternates 16'h00FF and 16'h00F0.
  - Clearing blink_en restores a steady 16'h00FF.
- PWM with `LED_PWM_EN` defined, DATA_LO=16'h0001:
  - CTRL duty=8'h40: `ledout[0]` is high for exactly 64 of every 256 cycles.
  - duty=0: always low.
  - duty=8'hFF: always high.
- Mid-operation reset: assert `ledrst` while blinking -> `ledout`=0 asynchronously; after release, CTRL reads 16'h00FF and phase=1.
- PERIOD write coincident with a tick -> the blink counter reads 0 and phase is 1 after that edge, with no toggle.

Source files
------------

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: up to 32 LED bits with per-LED blinking, PWM dimming and readback.
// Optional build macro LED_PWM_EN enables the PWM counter and the CTRL duty field.
module led_ctrl #(
    parameter int LED_W   = 16,
    parameter int PRESC_W = 22
) (
    input  logic             led_clk,
    input  logic             ledrst,
    input  logic             ledcs,
    input  logic             ledwrite,
    input  logic [2:0]       ledaddr,
    input  logic [15:0]      ledwdata,
    output logic [15:0]      ledrdata,
    output logic [LED_W-1:0] ledout
);

    // Bits at or above LED_W are forced to zero on write, so they read 0 and drive nothing.
    localparam logic [31:0] WMASK = (LED_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LED_W) - 32'd1);

    logic [31:0]        data, mask;
    logic [7:0]         duty;
    logic               blink_en;
    logic [15:0]        period, blink_cnt;
    logic               phase;
    logic [PRESC_W-1:0] presc;
    logic               tick, pwm_on, wr;

    assign wr   = ledcs & ledwrite;
    assign tick = &presc;

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            data     <= '0;
            mask     <= '0;
            blink_en <= 1'b0;
            period   <= '0;
        end else if (wr) begin
            case (ledaddr)
                3'd0: data[15:0]  <= ledwdata & WMASK[15:0];
                3'd1: data[31:16] <= ledwdata & WMASK[31:16];
                3'd2: mask[15:0]  <= ledwdata & WMASK[15:0];
                3'd3: mask[31:16] <= ledwdata & WMASK[31:16];
                3'd4: blink_en    <= ledwdata[8];
                3'd5: period      <= ledwdata;
                default: ;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            duty    <= 8'hFF;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr && ledaddr == 3'd4) duty <= ledwdata[7:0];
        end
    end

    assign pwm_on = (duty == 8'hFF) | (pwm_cnt < duty);
`else
    assign duty   = 8'hFF;
    assign pwm_on = 1'b1;
`endif

    // A PERIOD write restarts the blink sequence and wins over a same-cycle tick.
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            presc     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            presc <= presc + PRESC_W'(1);
            if (wr && ledaddr == 3'd5) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (tick) begin
                if (blink_cnt == period) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) ledout <= '0;
        else ledout <= data[LED_W-1:0]
                     & (~(mask[LED_W-1:0] & {LED_W{blink_en}}) | {LED_W{phase}})
                     & {LED_W{pwm_on}};
    end

    always_comb begin
        ledrdata = '0;
        if (ledcs) begin
            case (ledaddr)
                3'd0: ledrdata = data[15:0];
                3'd1: ledrdata = data[31:16];
                3'd2: ledrdata = mask[15:0];
                3'd3: ledrdata = mask[31:16];
                3'd4: ledrdata = {7'd0, blink_en, duty};
                3'd5: ledrdata = period;
                default: ledrdata = '0;
            endcase
        end
    end

endmodule
